sodor_imem_responder: RTL and testbench

Instruction-memory responder for the Sodor 5-stage core's fetch port. It accepts fetch requests (address plus valid) and returns 32-bit instruction words in request order after a configurable latency. Words come from a 16-entry program store that can be written at runtime. It replaces the zero-latency combinational program array in the two-copy security benches, so fetch timing becomes a real, testable handshake.

---
 rtl/sodor_mem_pkg.sv | 13 +
 rtl/sodor_imem_rom.sv | 30 +++
 rtl/sodor_imem_responder.sv | 114 +++++++++++
 tb/tb_sodor_imem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sodor_mem_pkg.sv
// Shared constants and queue entry type for the Sodor instruction-memory responder.
package sodor_mem_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int unsigned PROG_WORDS = 16;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [2:0]  age;
    } imem_entry_t;

endpackage

// File: rtl/sodor_imem_rom.sv
// 16x32 runtime-writable program store: one synchronous write port and one
// combinational read port, with every word reset to NOP.
module sodor_imem_rom
    import sodor_mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        we,
    input  logic [3:0]  widx,
    input  logic [31:0] wdata,
    input  logic [3:0]  ridx,
    output logic [31:0] rdata
);

    logic [31:0] mem_q [PROG_WORDS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PROG_WORDS; i++) begin
                mem_q[i] <= NOP_INSTR;
            end
        end else if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    // Read sees the pre-write word, so a same-edge fetch gets the old instruction.
    assign rdata = mem_q[ridx];

endmodule

// File: rtl/sodor_imem_responder.sv
// Fetch-port responder: reads the program store at request acceptance and returns
// words in order through an aging circular queue after LATENCY cycles.
module sodor_imem_responder
    import sodor_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [31:0]                req_addr,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [31:0]                resp_data,
    output logic                       resp_err,
    input  logic                       flush,
    input  logic                       prog_we,
    input  logic [3:0]                 prog_idx,
    input  logic [31:0]                prog_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] AGE_MAX = 3'(LATENCY);

    imem_entry_t   ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;

    logic        push, pop;
    logic [31:0] rom_rdata;
    imem_entry_t new_entry;
    imem_entry_t head_entry;
    logic        unused_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    sodor_imem_rom u_rom (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (prog_we),
        .widx    (prog_idx),
        .wdata   (prog_data),
        .ridx    (req_addr[5:2]),
        .rdata   (rom_rdata)
    );

    assign unused_addr = ^{req_addr[31:6]};

    assign req_ready  = !flush && (count_q < CW'(DEPTH));
    assign push       = req_valid && req_ready;
    assign head_entry = ent_q[head_q];
    assign resp_valid = vld_q[head_q] && (head_entry.age >= AGE_MAX);
    assign pop        = resp_valid && resp_ready;
    assign resp_data  = resp_valid ? head_entry.data : 32'h0;
    assign resp_err   = resp_valid && head_entry.err;
    assign occupancy  = count_q;

    always_comb begin
        new_entry.err  = (req_addr[1:0] != 2'b00);
        new_entry.data = new_entry.err ? NOP_INSTR : rom_rdata;
        new_entry.age  = 3'd1;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && (ent_q[i].age < AGE_MAX)) begin
                    ent_q[i].age <= ent_q[i].age + 3'd1;
                end
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= ptr_inc(head_q);
            end
            // Tail slot is never the popped slot: push needs a free slot.
            if (push) begin
                vld_q[tail_q] <= 1'b1;
                ent_q[tail_q] <= new_entry;
                tail_q        <= ptr_inc(tail_q);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_sodor_imem_responder.sv
// Directed bench for sodor_imem_responder with a queue scoreboard and a
// negedge monitor that checks every presented response.
module tb_sodor_imem_responder;

    localparam int unsigned LAT = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        bit          exact;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        flush;
    logic        prog_we;
    logic [3:0]  prog_idx;
    logic [31:0] prog_data;
    logic [2:0]  occupancy;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    sodor_imem_responder #(
        .LATENCY (LAT),
        .DEPTH   (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .flush      (flush),
        .prog_we    (prog_we),
        .prog_idx   (prog_idx),
        .prog_data  (prog_data),
        .occupancy  (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compares the head response against the scoreboard front.
    always @(negedge clock) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got data %h err %b expected no response",
                         resp_data, resp_err);
            end else begin
                check("resp_data", resp_data, sb[0].data);
                check("resp_err", 32'(resp_err), 32'(sb[0].err));
                if (resp_ready) begin
                    if (sb[0].exact)
                        check("resp_latency", 32'(cyc), 32'(sb[0].cyc + int'(LAT)));
                    else
                        check("resp_not_early", 32'(cyc >= sb[0].cyc + int'(LAT)), 32'd1);
                    void'(sb.pop_front());
                end
            end
        end else begin
            check("idle_data", resp_data, 32'h0);
            check("idle_err", 32'(resp_err), 32'h0);
        end
    end

    // Starts at posedge+1, ends at the next posedge+1.
    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic err,
                         input bit exact, input bit accept);
        exp_t e;
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clock);
        check("req_ready", 32'(req_ready), 32'(accept));
        if (req_ready) begin
            e.data  = data;
            e.err   = err;
            e.cyc   = cyc;
            e.exact = exact;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] idx, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_idx  = idx;
        prog_data = data;
        @(posedge clock);
        #1;
        prog_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        int budget = 50;
        while ((sb.size() != 0 || occupancy != 0) && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        #1;
        check(name, 32'(sb.size() == 0 && occupancy == 0), 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b1;
        flush      = 1'b0;
        prog_we    = 1'b0;
        prog_idx   = '0;
        prog_data  = '0;

        #3;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        issue(32'h0, NOP, 1'b0, 1'b1, 1'b1);
        drain("drain_reset_fetch");

        write_word(4'd2, 32'h0640_0083);
        issue(32'h8, 32'h0640_0083, 1'b0, 1'b1, 1'b1);
        issue(32'h48, 32'h0640_0083, 1'b0, 1'b1, 1'b1);
        drain("drain_programmed");

        // Distinct words so out-of-order draining is visible.
        for (int i = 0; i < 5; i++) write_word(4'(i), 32'hA000_0000 + 32'(i));
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
        issue(32'h10, 32'hA000_0004, 1'b0, 1'b0, 1'b0);
        check("bp_occupancy_full", 32'(occupancy), 32'd4);
        idle(3);
        resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("bp_drain_3", 32'(occupancy), 32'd1);
        @(posedge clock);
        @(negedge clock);
        check("bp_drain_4", 32'(occupancy), 32'd0);
        @(posedge clock);
        #1;

        issue(32'h6, NOP, 1'b1, 1'b1, 1'b1);
        drain("drain_misaligned");

        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            issue(32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h4;
        @(negedge clock);
        check("flush_req_ready", 32'(req_ready), 32'd0);
        @(posedge clock);
        sb.delete();
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        check("flush_occupancy", 32'(occupancy), 32'd0);
        @(posedge clock);
        #1;
        resp_ready = 1'b1;
        idle(6);

        prog_we   = 1'b1;
        prog_idx  = 4'd3;
        prog_data = 32'h00A0_0093;
        issue(32'hC, 32'hA000_0003, 1'b0, 1'b1, 1'b1);
        prog_we = 1'b0;
        issue(32'hC, 32'h00A0_0093, 1'b0, 1'b1, 1'b1);
        drain("drain_write_race");

        resp_ready = 1'b0;
        issue(32'h0, 32'hA000_0000, 1'b0, 1'b0, 1'b1);
        issue(32'h4, 32'hA000_0001, 1'b0, 1'b0, 1'b1);
        idle(2);
        #2 reset_n = 1'b0;
        #1;
        check("arst_resp_valid", 32'(resp_valid), 32'd0);
        check("arst_resp_data", resp_data, 32'h0);
        check("arst_resp_err", 32'(resp_err), 32'd0);
        check("arst_occupancy", 32'(occupancy), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd1);
        sb.delete();
        @(posedge clock);
        #1 reset_n = 1'b1;
        resp_ready = 1'b1;
        issue(32'hC, NOP, 1'b0, 1'b1, 1'b1);
        drain("drain_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
